antares_load_store_unit: RTL and testbench

ANTARES_LOAD_STORE_UNIT -- requirements
Module: antares_load_store_unit

---
 rtl/antares_pkg.sv | 15 +
 rtl/antares_load_store_unit_if.sv | 35 +++
 rtl/antares_lsu_align.sv | 26 ++
 rtl/antares_load_store_unit.sv | 107 ++++++++++
 tb/tb_antares_load_store_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/antares_pkg.sv
// antares_pkg: shared FSM encodings and big-endian byte-enable constants for the load/store unit
package antares_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRAIN} state_t;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0 = 4'b1000;
  localparam logic [3:0] BE_B1 = 4'b0100;
  localparam logic [3:0] BE_B2 = 4'b0010;
  localparam logic [3:0] BE_B3 = 4'b0001;
  localparam logic [3:0] BE_H0 = 4'b1100;
  localparam logic [3:0] BE_H1 = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  function automatic logic [3:0] byte_be(input logic [1:0] a);
    return a == 2'd0 ? BE_B0 : a == 2'd1 ? BE_B1 : a == 2'd2 ? BE_B2 : BE_B3;
  endfunction
endpackage

// File: rtl/antares_load_store_unit_if.sv
// antares_load_store_unit_if: MEM-stage request signals and data-port bus of the load/store unit
interface antares_load_store_unit_if;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic mem_write;
  logic mem_read;
  logic mem_byte;
  logic mem_halfword;
  logic mem_sign_extend;
  logic mem_llsc;
  logic mem_kernel_mode;
  logic exception_flush;
  logic [31:0] dport_data_i;
  logic dport_ready;
  logic [31:0] dport_address;
  logic [31:0] dport_data_o;
  logic [3:0] dport_wr;
  logic dport_enable;
  logic [31:0] mem_data_out;
  logic mem_stall;
  logic exc_address_l_mem;
  logic exc_address_s_mem;
  modport master (
    output mem_address, mem_data_in, mem_write, mem_read, mem_byte, mem_halfword,
           mem_sign_extend, mem_llsc, mem_kernel_mode, exception_flush, dport_data_i, dport_ready,
    input dport_address, dport_data_o, dport_wr, dport_enable, mem_data_out, mem_stall,
          exc_address_l_mem, exc_address_s_mem
  );
  modport slave (
    input mem_address, mem_data_in, mem_write, mem_read, mem_byte, mem_halfword,
          mem_sign_extend, mem_llsc, mem_kernel_mode, exception_flush, dport_data_i, dport_ready,
    output dport_address, dport_data_o, dport_wr, dport_enable, mem_data_out, mem_stall,
           exc_address_l_mem, exc_address_s_mem
  );
endinterface

// File: rtl/antares_lsu_align.sv
// antares_lsu_align: big-endian store lane steering and load lane extraction with sign/zero extension
module antares_lsu_align
  import antares_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic        i_byte,
  input  logic        i_half,
  input  logic        i_sign,
  input  logic [31:0] i_store,
  input  logic [31:0] i_load,
  output logic [3:0]  o_be,
  output logic [31:0] o_store,
  output logic [31:0] o_load
);
  logic [31:0] w_sh;
  logic [7:0]  w_b;
  logic [15:0] w_h;
  // shifting the addressed lane to the top makes byte/halfword extraction a fixed slice
  assign w_sh = i_load << {i_addr, 3'b000};
  assign w_b = w_sh[31:24];
  assign w_h = w_sh[31:16];
  assign o_be = i_byte ? byte_be(i_addr) : i_half ? (i_addr[1] ? BE_H1 : BE_H0) : BE_W;
  assign o_store = i_byte ? {4{i_store[7:0]}} : i_half ? {2{i_store[15:0]}} : i_store;
  assign o_load = i_byte ? {{24{i_sign & w_b[7]}}, w_b} :
                  i_half ? {{16{i_sign & w_h[15]}}, w_h} : i_load;
endmodule

// File: rtl/antares_load_store_unit.sv
// antares_load_store_unit: MEM-stage load/store unit with IDLE/WAIT/DRAIN bus FSM and LL/SC link bit
module antares_load_store_unit
  import antares_pkg::*;
(
  input logic clk,
  input logic rst,
  antares_load_store_unit_if.slave bus
);
  state_t r_state, w_next;
  logic [31:0] r_addr, r_data;
  logic r_byte, r_half, r_sign, r_llsc, r_write, r_read, r_llbit;
  logic w_idle, w_err, w_sc_fail, w_valid, w_done, w_en, w_stall;
  logic w_byte, w_half, w_sign, w_write;
  logic [31:0] w_a, w_d, w_store, w_load;
  logic [3:0] w_be;
  assign w_idle = r_state == ST_IDLE;
  assign w_err = (bus.mem_halfword & bus.mem_address[0]) |
                 (~bus.mem_byte & ~bus.mem_halfword & |bus.mem_address[1:0]) |
                 (~bus.mem_kernel_mode & bus.mem_address[31]);
  assign w_sc_fail = bus.mem_write & bus.mem_llsc & ~r_llbit;
  assign w_valid = (bus.mem_read | bus.mem_write) & ~bus.exception_flush & ~w_err & ~w_sc_fail;
  // issue cycle drives the bus from live inputs, later cycles from the latched copy
  assign w_a = w_idle ? bus.mem_address : r_addr;
  assign w_d = w_idle ? bus.mem_data_in : r_data;
  assign w_byte = w_idle ? bus.mem_byte : r_byte;
  assign w_half = w_idle ? bus.mem_halfword : r_half;
  assign w_sign = w_idle ? bus.mem_sign_extend : r_sign;
  assign w_write = w_idle ? bus.mem_write : r_write;
  antares_lsu_align u_align (
    .i_addr (w_a[1:0]),
    .i_byte (w_byte),
    .i_half (w_half),
    .i_sign (w_sign),
    .i_store(w_d),
    .i_load (bus.dport_data_i),
    .o_be   (w_be),
    .o_store(w_store),
    .o_load (w_load)
  );
  always_comb begin
    w_next = r_state;
    w_en = 1'b0;
    w_stall = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_en = w_valid;
        w_stall = w_valid;
        w_next = w_valid ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        w_en = 1'b1;
        w_stall = ~bus.dport_ready;
        w_done = bus.dport_ready & ~bus.exception_flush;
        w_next = bus.dport_ready ? ST_IDLE : bus.exception_flush ? ST_DRAIN : ST_WAIT;
      end
      ST_DRAIN: begin
        w_en = 1'b1;
        w_stall = 1'b1;
        w_next = bus.dport_ready ? ST_IDLE : ST_DRAIN;
      end
      default: w_next = ST_IDLE;
    endcase
    if (rst) begin
      w_en = 1'b0;
      w_stall = 1'b0;
      w_done = 1'b0;
    end
  end
  assign bus.dport_enable = w_en;
  assign bus.mem_stall = w_stall;
  assign bus.dport_address = {w_a[31:2], 2'b00};
  assign bus.dport_data_o = w_store;
  assign bus.dport_wr = (w_en & w_write) ? w_be : BE_NONE;
  assign bus.mem_data_out = ~w_done ? 32'd0 : (r_llsc & r_write) ? 32'd1 : r_read ? w_load : 32'd0;
  assign bus.exc_address_l_mem = w_err & bus.mem_read;
  assign bus.exc_address_s_mem = w_err & bus.mem_write;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr <= '0;
      r_data <= '0;
      r_byte <= 1'b0;
      r_half <= 1'b0;
      r_sign <= 1'b0;
      r_llsc <= 1'b0;
      r_write <= 1'b0;
      r_read <= 1'b0;
      r_llbit <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle & w_valid) begin
        r_addr <= bus.mem_address;
        r_data <= bus.mem_data_in;
        r_byte <= bus.mem_byte;
        r_half <= bus.mem_halfword;
        r_sign <= bus.mem_sign_extend;
        r_llsc <= bus.mem_llsc;
        r_write <= bus.mem_write;
        r_read <= bus.mem_read;
      end
      // LL completion sets the link, SC completion consumes it, flush always breaks it
      if (bus.exception_flush) r_llbit <= 1'b0;
      else if (w_done & r_llsc) r_llbit <= r_read;
    end
  end
endmodule

// File: tb/tb_antares_load_store_unit.sv
// tb_antares_load_store_unit: scoreboard bench for the load/store unit with a cycle-driven bus model
module tb_antares_load_store_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  antares_load_store_unit_if bus();
  antares_load_store_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic clear_req();
    bus.mem_read = 0;
    bus.mem_write = 0;
    bus.mem_llsc = 0;
    bus.mem_byte = 0;
    bus.mem_halfword = 0;
    bus.mem_sign_extend = 0;
    bus.mem_kernel_mode = 1;
    bus.exception_flush = 0;
    bus.dport_ready = 0;
    bus.dport_data_i = 0;
  endtask
  task automatic run(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input logic is_wr, input logic is_byte,
                     input logic is_half, input logic sgn, input logic llsc, input int waits,
                     input logic [3:0] exp_wr, input logic [31:0] exp_do, input logic [31:0] exp_out);
    int stalls;
    logic [31:0] e;
    @(posedge clk); #1;
    bus.mem_address = addr;
    bus.mem_data_in = wdata;
    bus.mem_write = is_wr;
    bus.mem_read = ~is_wr;
    bus.mem_byte = is_byte;
    bus.mem_halfword = is_half;
    bus.mem_sign_extend = sgn;
    bus.mem_llsc = llsc;
    sb.push_back(exp_out);
    stalls = 0;
    @(negedge clk);
    chk({tag, " en"}, bus.dport_enable, 1);
    chk({tag, " addr"}, bus.dport_address, {addr[31:2], 2'b00});
    chk({tag, " wr"}, bus.dport_wr, exp_wr);
    if (is_wr) chk({tag, " dout"}, bus.dport_data_o, exp_do);
    stalls += bus.mem_stall;
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " en_wait"}, bus.dport_enable, 1);
      chk({tag, " out_wait"}, bus.mem_data_out, 0);
      stalls += bus.mem_stall;
    end
    @(posedge clk); #1;
    bus.dport_ready = 1;
    bus.dport_data_i = rdata;
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, " stall_done"}, bus.mem_stall, 0);
    chk({tag, " wr_done"}, bus.dport_wr, exp_wr);
    if (is_wr) chk({tag, " dout_done"}, bus.dport_data_o, exp_do);
    chk({tag, " out"}, bus.mem_data_out, e);
    chk({tag, " stalls"}, stalls, waits + 1);
    @(posedge clk); #1;
    clear_req();
  endtask
  task automatic quick(input string tag, input logic [31:0] addr, input logic rd, input logic wr,
                       input logic half, input logic kern, input logic llsc, input logic flush,
                       input logic exp_l, input logic exp_s);
    @(posedge clk); #1;
    bus.mem_address = addr;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.mem_halfword = half;
    bus.mem_kernel_mode = kern;
    bus.mem_llsc = llsc;
    bus.exception_flush = flush;
    @(negedge clk);
    chk({tag, " en"}, bus.dport_enable, 0);
    chk({tag, " stall"}, bus.mem_stall, 0);
    chk({tag, " out"}, bus.mem_data_out, 0);
    chk({tag, " exc_l"}, bus.exc_address_l_mem, exp_l);
    chk({tag, " exc_s"}, bus.exc_address_s_mem, exp_s);
    @(posedge clk); #1;
    clear_req();
  endtask
  initial begin
    bus.mem_address = 0;
    bus.mem_data_in = 0;
    clear_req();
    bus.mem_read = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst en", bus.dport_enable, 0);
    chk("rst stall", bus.mem_stall, 0);
    chk("rst wr", bus.dport_wr, 0);
    chk("rst out", bus.mem_data_out, 0);
    @(posedge clk); #1;
    bus.mem_read = 0;
    rst = 0;
    @(negedge clk);
    chk("post_rst en", bus.dport_enable, 0);
    run("sb_byte", 32'h1002, 32'h000000A5, 0, 1, 1, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, 0);
    run("lh_sign", 32'h2002, 0, 32'h1234F00D, 0, 0, 1, 1, 0, 3, 4'b0000, 0, 32'hFFFFF00D);
    run("lh_zero", 32'h2000, 0, 32'h8765F00D, 0, 0, 1, 0, 0, 1, 4'b0000, 0, 32'h00008765);
    run("lbu", 32'h5001, 0, 32'h11C32244, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 32'h000000C3);
    run("lb", 32'h5001, 0, 32'h11C32244, 0, 1, 0, 1, 0, 2, 4'b0000, 0, 32'hFFFFFFC3);
    run("lb3", 32'h5003, 0, 32'h00000080, 0, 1, 0, 1, 0, 0, 4'b0000, 0, 32'hFFFFFF80);
    run("lw", 32'h6000, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 32'hDEADBEEF);
    run("sh0", 32'h7000, 32'h0000BEEF, 0, 1, 0, 1, 0, 0, 1, 4'b1100, 32'hBEEFBEEF, 0);
    run("sh1", 32'h7002, 32'h00001234, 0, 1, 0, 1, 0, 0, 0, 4'b0011, 32'h12341234, 0);
    run("sb0", 32'h7000, 32'h0000005A, 0, 1, 1, 0, 0, 0, 0, 4'b1000, 32'h5A5A5A5A, 0);
    run("sw", 32'h7004, 32'h89ABCDEF, 0, 1, 0, 0, 0, 0, 0, 4'b1111, 32'h89ABCDEF, 0);
    quick("lw_unal", 32'h3001, 1, 0, 0, 1, 0, 0, 1, 0);
    quick("lw_user", 32'h80000000, 1, 0, 0, 0, 0, 0, 1, 0);
    quick("sh_unal", 32'h00000001, 0, 1, 1, 1, 0, 0, 0, 1);
    quick("flush_idle", 32'h4000, 1, 0, 0, 1, 0, 1, 0, 0);
    quick("sc_nolink0", 32'h4000, 0, 1, 0, 1, 1, 0, 0, 0);
    run("ll", 32'h4000, 0, 32'hCAFE0001, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'hCAFE0001);
    run("sc_ok", 32'h4000, 32'h12345678, 0, 1, 0, 0, 0, 1, 1, 4'b1111, 32'h12345678, 32'd1);
    quick("sc_again", 32'h4000, 0, 1, 0, 1, 1, 0, 0, 0);
    run("ll2", 32'h4000, 0, 32'h00000042, 0, 0, 0, 0, 1, 0, 4'b0000, 0, 32'h00000042);
    @(posedge clk); #1;
    bus.mem_address = 32'h4000;
    bus.mem_read = 1;
    bus.mem_llsc = 1;
    sb.push_back(0);
    @(negedge clk);
    chk("fl en", bus.dport_enable, 1);
    @(posedge clk); #1;
    bus.exception_flush = 1;
    @(negedge clk);
    chk("fl wait_stall", bus.mem_stall, 1);
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("fl drain_en", bus.dport_enable, 1);
    chk("fl drain_stall", bus.mem_stall, 1);
    @(posedge clk); #1;
    bus.dport_ready = 1;
    bus.dport_data_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("fl ready_stall", bus.mem_stall, 1);
    chk("fl out", bus.mem_data_out, sb.pop_front());
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    chk("fl idle_en", bus.dport_enable, 0);
    chk("fl idle_stall", bus.mem_stall, 0);
    quick("sc_after_fl", 32'h4000, 0, 1, 0, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    bus.mem_address = 32'h6000;
    bus.mem_read = 1;
    @(negedge clk);
    chk("rw en", bus.dport_enable, 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rw rst_en", bus.dport_enable, 0);
    chk("rw rst_stall", bus.mem_stall, 0);
    @(posedge clk); #1;
    rst = 0;
    bus.mem_read = 0;
    bus.dport_ready = 1;
    bus.dport_data_i = 32'h11111111;
    @(negedge clk);
    chk("rw late_stall", bus.mem_stall, 0);
    chk("rw late_out", bus.mem_data_out, 0);
    chk("rw late_en", bus.dport_enable, 0);
    @(posedge clk); #1;
    clear_req();
    chk("sb empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
